// File: rtl/tt_sweep.sv
// Truth-table sweeper: steps {a,b,c} through all eight vectors of a 3-input
// combinational block, captures its output y and scores it against EXPECTED.
module tt_sweep #(
    parameter logic [7:0]  EXPECTED = 8'h39,
    parameter int unsigned SETTLE   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] err_count,
    output logic [2:0] first_fail,
    output logic       fail_seen
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] wait_cnt;
    logic       miss;
    logic [3:0] err_next;

    // pass must reflect the count including the final sample, so score it combinationally
    always_comb begin
        miss     = (y != EXPECTED[idx]);
        err_next = err_count + {3'b000, miss};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= 3'd0;
            wait_cnt   <= 4'd0;
            {a, b, c}  <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            captured   <= 8'h00;
            err_count  <= 4'd0;
            first_fail <= 3'd0;
            fail_seen  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    {a, b, c} <= 3'b000;
                    done      <= 1'b0;
                    if (start) begin
                        captured   <= 8'h00;
                        err_count  <= 4'd0;
                        first_fail <= 3'd0;
                        fail_seen  <= 1'b0;
                        pass       <= 1'b0;
                        idx        <= 3'd0;
                        wait_cnt   <= 4'd0;
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    captured[idx] <= y;
                    err_count     <= err_next;
                    if (miss && !fail_seen) begin
                        first_fail <= idx;
                        fail_seen  <= 1'b1;
                    end
                    if (idx == 3'd7) begin
                        {a, b, c} <= 3'b000;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (err_next == 4'd0);
                        state     <= ST_DONE;
                    end else begin
                        idx       <= idx + 3'd1;
                        {a, b, c} <= idx + 3'd1;
                        wait_cnt  <= 4'd0;
                        state     <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tt_sweep.md
# tt_sweep

Sequential truth-table sweeper that drives the three inputs of a 3-input combinational block, such as the exercise 4.9/4.10 function, through all eight input vectors. It samples the block's single output for each vector, builds the captured 8-entry truth table, and compares it against an expected table. It sits directly upstream of the combinational block, which it feeds, and directly downstream of it, which it consumes. This provides a reusable on-chip self-check for the chapter 4 combinational exercises.

## Interface
- EXPECTED, 8'h39, expected truth table; bit i = required y for {a,b,c} = i (8'h39 is the 4.9/4.10 function).
- SETTLE, 1, cycles each vector is held before its sample cycle; legal range 1..15.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- start  input  1  request a sweep; accepted only in IDLE
- y  input  1  output of the combinational block under test
- a, b, c  output  1 each  drive vector {a,b,c} to the block under test
- busy  output  1  high while a sweep is in progress (SETTLE or SAMPLE state)
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  captured == EXPECTED; valid from done, held until next accepted start
- captured  output  8  captured truth table, bit i = sampled y for vector i
- err_count  output  4  number of mismatching entries, 0..8
- first_fail  output  3  lowest vector index that mismatched; 0 if none
- fail_seen  output  1  at least one mismatch so far in the current or last sweep

## Operation
- All outputs are registered. Reset values: a=b=c=0, busy=0, done=0, pass=0, captured=8'h00, err_count=0, first_fail=0, fail_seen=0. Internal: state=IDLE, idx=0, wait counter=0.
- IDLE state:
  - {a,b,c}=000.
  - start=1 → clear captured, err_count, first_fail, fail_seen, pass; idx←0; wait←0; go to SETTLE.
- SETTLE state:
  - {a,b,c}=idx.
  - Wait counter increments each cycle.
  - When wait==SETTLE-1, go to SAMPLE.
- SAMPLE state:
  - {a,b,c} stays at idx.
  - On the edge: captured[idx]←y.
  - If y != EXPECTED[idx]: err_count+=1; if fail_seen==0, then first_fail←idx and fail_seen←1.
  - If idx==7 → DONE. Otherwise idx+=1, wait←0, go to SETTLE.
- DONE state:
  - done=1 for exactly this one cycle.
  - pass = (err_count==0), computed from the final updated values.
  - {a,b,c}=000.
  - Go to IDLE on the next edge.
- start is ignored in SETTLE, SAMPLE and DONE. No queuing.
- After a sweep, captured, err_count, first_fail, fail_seen and pass hold until the next accepted start or reset.
- Arithmetic:
  - idx is 3 bits and never wraps during a sweep; the sweep terminates at 7.
  - err_count is 4 bits, maximum value 8, no saturation needed.
  - y is compared as a 2-state value.
- Reset mid-sweep aborts the sweep. Every output returns to its reset value on the reset edge. No done pulse is produced.
- reset and start high in the same cycle: reset wins.

## Timing
- Let E0 be the edge at which start is accepted, and S = SETTLE.
- Vector k (k = 0..7) appears on {a,b,c} after edge E(k·(S+1)).
- Vector k is sampled at edge E((k+1)·(S+1)). It is therefore stable for S+1 cycles before sampling; the block under test is purely combinational.
- busy rises after E0 and falls after E(8·(S+1)).
- done is high during the cycle after E(8·(S+1)). For S=1, done is high after E16.
- The state is IDLE after E(8·(S+1)+1). The earliest next accepted start is at that edge's following cycle.
- Sweep-to-sweep period: 8·(S+1)+2 cycles minimum.

## Test plan
- Correct block, S=1, pulse start at E0:
  - {a,b,c} steps 000..111, each held 2 cycles.
  - done pulses once after E16.
  - captured=8'h39, err_count=0, pass=1, fail_seen=0.
- Faulty block, y tied 0, S=1:
  - captured=8'h00, err_count=4, first_fail=0, fail_seen=1, pass=0.
  - Then y tied 1 with a new start: captured=8'hFF, err_count=4, first_fail=1, pass=0.
- Extra start pulses at cycles 5 and 17 (during the DONE cycle), S=1:
  - Exactly one done pulse after E16; results unchanged.
  - A start at cycle 18 begins a new sweep.
- Reset asserted for one cycle at cycle 7 mid-sweep:
  - All outputs take their reset values on that edge; no done pulse.
  - A subsequent start completes normally with pass=1.
- S=3, correct block:
  - Each vector is held 4 cycles.
  - done after E32; captured=8'h39, pass=1.
